// File: rtl/mux_scan_ctrl_if.sv
// Handshake and data bundle between a scan requester and the 8:1 mux scan controller.
// The slave modport is the controller; the master modport is the requester and mux side.
interface mux_scan_ctrl_if;
  logic       start;
  logic       dir;
  logic       mux_in;
  logic [2:0] sel;
  logic [7:0] data;
  logic       busy;
  logic       done;

  modport master (
    output start,
    output dir,
    output mux_in,
    input  sel,
    input  data,
    input  busy,
    input  done
  );

  modport slave (
    input  start,
    input  dir,
    input  mux_in,
    output sel,
    output data,
    output busy,
    output done
  );
endinterface

// File: rtl/mux_scan_ctrl.sv
// Walks an external 8:1 mux select through all inputs, holding each for DWELL cycles,
// and assembles the returned serial bits into a byte (bit k = mux input k).
module mux_scan_ctrl #(
  parameter int unsigned DWELL = 1
) (
  input  logic           clk,
  input  logic           rst,
  mux_scan_ctrl_if.slave bus
);

  localparam int unsigned SEL_W  = 3;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 4;

  localparam logic [SEL_W-1:0] SEL_LO = SEL_W'(0);
  localparam logic [SEL_W-1:0] SEL_HI = SEL_W'(7);

  if ((DWELL < 1) || (DWELL > 15)) begin : g_dwell_range
    $fatal(1, "mux_scan_ctrl: DWELL=%0d outside legal range 1..15", DWELL);
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  logic              r_dir;
  logic [CNT_W-1:0]  r_cnt;
  logic [SEL_W-1:0]  r_sel;
  logic [DATA_W-1:0] r_data;
  logic              r_busy;
  logic              r_done;

  logic w_capture;
  logic w_last;

  assign w_capture = (r_cnt == CNT_W'(DWELL - 1));
  // The final index depends on the direction latched at start, so sel never wraps.
  assign w_last    = r_dir ? (r_sel == SEL_LO) : (r_sel == SEL_HI);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_dir   <= 1'b0;
      r_cnt   <= '0;
      r_sel   <= SEL_LO;
      r_data  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          r_sel <= SEL_LO;
          if (bus.start) begin
            r_state <= S_SCAN;
            r_dir   <= bus.dir;
            r_cnt   <= '0;
            r_data  <= '0;
            r_sel   <= bus.dir ? SEL_HI : SEL_LO;
            r_busy  <= 1'b1;
          end
        end
        S_SCAN: begin
          if (w_capture) begin
            r_data[r_sel] <= bus.mux_in;
            r_cnt         <= '0;
            if (w_last) begin
              r_state <= S_DONE;
              r_sel   <= SEL_LO;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_sel <= r_dir ? (r_sel - SEL_W'(1)) : (r_sel + SEL_W'(1));
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_sel   <= SEL_LO;
        end
        default: begin
          r_state <= S_IDLE;
          r_sel   <= SEL_LO;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.sel  = r_sel;
  assign bus.data = r_data;
  assign bus.busy = r_busy;
  assign bus.done = r_done;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench for mux_scan_ctrl: one instance at DWELL=1 and one at DWELL=3,
// each fed by an 8:1 mux model driven from a byte of input values.
module tb_mux_scan_ctrl;

  logic clk;
  logic rst1;
  logic rst3;
  logic [7:0] bits1;
  logic [7:0] bits3;
  logic       glitch3;

  int checks;
  int failures;

  mux_scan_ctrl_if if1 ();
  mux_scan_ctrl_if if3 ();

  mux_scan_ctrl #(.DWELL(1)) dut1 (.clk(clk), .rst(rst1), .bus(if1.slave));
  mux_scan_ctrl #(.DWELL(3)) dut3 (.clk(clk), .rst(rst3), .bus(if3.slave));

  // 8:1 mux models; glitch3 flips the currently selected input of the DWELL=3 mux.
  assign if1.mux_in = bits1[if1.sel];
  assign if3.mux_in = bits3[if3.sel] ^ glitch3;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Checks sel/busy/done of dut1 against the expected values.
  task automatic chk1(input string tag, input int sel, input bit busy, input bit done);
    chk({tag, "_sel"},  8'(if1.sel),  8'(sel));
    chk({tag, "_busy"}, 8'(if1.busy), 8'(busy));
    chk({tag, "_done"}, 8'(if1.done), 8'(done));
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    rst1       = 1'b1;
    rst3       = 1'b1;
    bits1      = 8'hB2;
    bits3      = 8'hB2;
    glitch3    = 1'b0;
    if1.start  = 1'b0;
    if1.dir    = 1'b0;
    if3.start  = 1'b0;
    if3.dir    = 1'b0;
    tick();
    tick();

    // Reset state.
    chk1("reset", 0, 1'b0, 1'b0);
    chk("reset_data", if1.data, 8'h00);
    chk("reset3_sel", 8'(if3.sel), 8'h00);
    rst1 = 1'b0;
    rst3 = 1'b0;
    tick();
    chk1("idle", 0, 1'b0, 1'b0);

    // DWELL=1, dir=0: sel 0..7, busy 8 cycles, done in cycle 9.
    if1.dir   = 1'b0;
    if1.start = 1'b1;
    tick();
    if1.start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk1("up_scan", k, 1'b1, 1'b0);
      tick();
    end
    chk1("up_done", 0, 1'b0, 1'b1);
    chk("up_data", if1.data, 8'hB2);
    tick();
    chk1("up_idle", 0, 1'b0, 1'b0);

    // DWELL=1, dir=1: sel 7..0; dir flips mid-scan must be ignored.
    if1.dir   = 1'b1;
    if1.start = 1'b1;
    tick();
    if1.start = 1'b0;
    if1.dir   = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk1("dn_scan", 7 - k, 1'b1, 1'b0);
      if (k == 3) if1.dir = 1'b1;
      if (k == 5) if1.dir = 1'b0;
      tick();
    end
    chk1("dn_done", 0, 1'b0, 1'b1);
    chk("dn_data", if1.data, 8'hB2);
    tick();
    chk1("dn_idle", 0, 1'b0, 1'b0);

    // DWELL=3: glitch the selected input only in the first dwell cycle.
    if3.dir   = 1'b0;
    if3.start = 1'b1;
    tick();
    if3.start = 1'b0;
    for (int idx = 0; idx < 8; idx++) begin
      for (int c = 0; c < 3; c++) begin
        chk("d3_sel",  8'(if3.sel),  8'(idx));
        chk("d3_busy", 8'(if3.busy), 8'h01);
        chk("d3_done", 8'(if3.done), 8'h00);
        glitch3 = (c == 0);
        tick();
      end
    end
    glitch3 = 1'b0;
    chk("d3_end_busy", 8'(if3.busy), 8'h00);
    chk("d3_end_done", 8'(if3.done), 8'h01);
    chk("d3_data",     if3.data,     8'hB2);
    tick();
    chk("d3_idle_done", 8'(if3.done), 8'h00);

    // Reset in the 4th SCAN cycle aborts without a done pulse.
    if1.dir   = 1'b0;
    if1.start = 1'b1;
    tick();
    if1.start = 1'b0;
    tick();
    tick();
    tick();
    chk1("abort_pre", 3, 1'b1, 1'b0);
    chk("abort_pre_data", if1.data, 8'h02);
    rst1 = 1'b1;
    tick();
    rst1 = 1'b0;
    chk1("abort_rst", 0, 1'b0, 1'b0);
    chk("abort_data", if1.data, 8'h00);
    tick();
    chk1("abort_nodone", 0, 1'b0, 1'b0);

    // Reset has priority over start in the same edge.
    rst1      = 1'b1;
    if1.start = 1'b1;
    tick();
    rst1      = 1'b0;
    if1.start = 1'b0;
    chk1("rst_prio", 0, 1'b0, 1'b0);

    // First start after reset completes normally.
    if1.start = 1'b1;
    tick();
    if1.start = 1'b0;
    for (int k = 0; k < 8; k++) tick();
    chk1("post_rst_done", 0, 1'b0, 1'b1);
    chk("post_rst_data", if1.data, 8'hB2);
    tick();

    // Data holds after done while inputs change, until the next start.
    bits1 = 8'h5A;
    tick();
    tick();
    tick();
    chk("hold_data", if1.data, 8'hB2);
    if1.start = 1'b1;
    tick();
    if1.start = 1'b0;
    chk("hold_clear", if1.data, 8'h00);
    for (int k = 0; k < 8; k++) tick();
    chk1("new_done", 0, 1'b0, 1'b1);
    chk("new_data", if1.data, 8'h5A);
    tick();

    // Start held high: period 10, done at n%10==8, start ignored outside IDLE.
    bits1     = 8'hB2;
    if1.start = 1'b1;
    tick();
    for (int n = 0; n <= 20; n++) begin
      chk1("bb", (n % 10 < 8) ? (n % 10) : 0, (n % 10) < 8, (n % 10) == 8);
      if (n == 8)  chk("bb_data1", if1.data, 8'hB2);
      if (n == 18) chk("bb_data2", if1.data, 8'h3C);
      if (n == 9)  bits1 = 8'h3C;
      tick();
    end
    if1.start = 1'b0;
    for (int k = 0; k < 12; k++) tick();
    chk1("bb_idle", 0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mux_scan_ctrl.md
MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

Interface
REQ-001: Parameter DWELL, default 1, clock cycles each select value is held (legal 1..15); the block SHALL treat DWELL as this.
REQ-002: clk  input  1  rising-edge clock; the block SHALL have one clock only.
REQ-003: rst  input  1  reset; the block SHALL use a synchronous, active-high reset.
REQ-004: start  input  1  scan request; the block SHALL sample it in IDLE only.
REQ-005: dir  input  1  scan order, 0 = index 0->7, 1 = index 7->0; the block SHALL latch it on an accepted start.
REQ-006: mux_in  input  1  serial bit returned from the downstream 8:1 mux output; the block SHALL capture it.
REQ-007: sel  output  3  select driven to the 8:1 mux sel input; the block SHALL drive it.
REQ-008: data  output  8  captured byte, bit k = mux input k; the block SHALL present it.
REQ-009: busy  output  1  the block SHALL assert it high in SCAN only.
REQ-010: done  output  1  the block SHALL pulse it for one cycle when a scan completes.

Function
REQ-011: The block SHALL implement states IDLE, SCAN, DONE; IDLE->SCAN on start=1 at a rising edge; SCAN->DONE after the 8th capture; DONE->IDLE unconditionally after one cycle.
REQ-012: On accepted start, the block SHALL clear data to 8'h00, clear the dwell counter, and set sel to 3'd0 (dir=0) or 3'd7 (dir=1) for the first SCAN cycle.
REQ-013: In SCAN, the block SHALL count the dwell counter 0..DWELL-1; at the edge where the counter = DWELL-1, it SHALL write data[sel] <= mux_in, reset the counter, and step sel by +1 (dir=0) or -1 (dir=1).
REQ-014: The block SHALL sample mux_in only at the capture edge; changes earlier in the dwell window SHALL NOT affect data.
REQ-015: The block SHALL NOT let sel wrap during a scan; the 8th capture (sel=7 for dir=0, sel=0 for dir=1) SHALL end SCAN.
REQ-016: The block SHALL drive sel to 3'd0 in IDLE and DONE.
REQ-017: Latency: if start is sampled at edge E0, the block SHALL hold busy high for exactly 8*DWELL cycles and SHALL assert done in the cycle following edge E0+8*DWELL.
REQ-018: The block SHALL ignore start in SCAN and DONE; a request is not queued.
REQ-019: With start held high, the block SHALL restart scans back-to-back with period 8*DWELL+2 cycles (DONE and IDLE each one cycle).
REQ-020: The block SHALL hold data stable from the DONE cycle until the next accepted start or reset.
REQ-021: The block SHALL ignore dir changes during SCAN.
REQ-022: If DWELL is outside 1..15, the block SHALL stop simulation with an error at elaboration.

Reset
REQ-023: With rst=1 at a rising edge, the block SHALL enter IDLE and set sel=3'd0, data=8'h00, busy=0, done=0, and dwell counter=0.
REQ-024: rst SHALL take priority over start and over any capture in the same edge.
REQ-025: rst asserted mid-scan SHALL abort the scan with no done pulse; the first start after rst deasserts SHALL be accepted normally.

Verification
REQ-026: The bench SHALL drive DWELL=1, dir=0, mux inputs 8'hB2 through an 8:1 mux model, start one cycle -> required: sel 0..7 in consecutive cycles, busy for 8 cycles, done in cycle 9, data=8'hB2.
REQ-027: The bench SHALL repeat REQ-026 with dir=1 -> required: sel 7,6,...,0, data=8'hB2, done timing unchanged.
REQ-028: The bench SHALL drive DWELL=3 and toggle the mux input for the current index in the first dwell cycle only, restoring it before the capture edge -> required: the restored value is captured, busy lasts 24 cycles, done in cycle 25.
REQ-029: The bench SHALL assert rst at the 4th SCAN cycle -> required: next cycle sel=0, data=8'h00, busy=0, no done pulse; a following start completes with data=8'hB2.
REQ-030: The bench SHALL hold start high continuously with DWELL=1 -> required: done pulses every 10 cycles, start pulses during SCAN and DONE are ignored, and data is refreshed each scan.
REQ-031: The bench SHALL change mux inputs to 8'h5A after done -> required: data stays 8'hB2 until the next start; the next scan yields 8'h5A.
